// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions: operand-select encodings for the 3-source
// configuration, the {data, err} beat type and the skid-buffer occupancy states.
package mips_pipe_pkg;

  localparam int MIPS_WIDTH   = 32;
  localparam int MIPS_NUM_SRC = 3;

  localparam logic [1:0] SEL_REG   = 2'd0;
  localparam logic [1:0] SEL_EXMEM = 2'd1;
  localparam logic [1:0] SEL_MEMWB = 2'd2;

  typedef struct packed {
    logic [MIPS_WIDTH-1:0] data;
    logic                  err;
  } operand_beat_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_e;

endpackage

// File: rtl/operand_skid_buf.sv
// Generic 2-entry valid/ready skid register. in_ready decodes the occupancy
// register only, so there is no combinational path from out_ready.
module operand_skid_buf
  import mips_pipe_pkg::*;
#(
  parameter int PAYLOAD_W = 33
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data
);

  occ_state_e           state_q, state_d;
  logic [PAYLOAD_W-1:0] main_q, main_d;
  logic [PAYLOAD_W-1:0] skid_q, skid_d;
  logic                 accept;
  logic                 deliver;

  assign accept  = in_valid && in_ready && !flush;
  assign deliver = out_valid && out_ready;

  // Occupancy and payload registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OCC_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Next occupancy and payload movement; flush wins over accept and deliver.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = OCC_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        OCC_EMPTY: begin
          if (accept) begin
            state_d = OCC_ONE;
            main_d  = in_data;
          end else begin
            state_d = OCC_EMPTY;
          end
        end
        OCC_ONE: begin
          if (accept && deliver) begin
            state_d = OCC_ONE;
            main_d  = in_data;
          end else if (accept) begin
            state_d = OCC_FULL;
            skid_d  = in_data;
          end else if (deliver) begin
            state_d = OCC_EMPTY;
          end else begin
            state_d = OCC_ONE;
          end
        end
        OCC_FULL: begin
          if (deliver) begin
            state_d = OCC_ONE;
            main_d  = skid_q;
          end else begin
            state_d = OCC_FULL;
          end
        end
        default: begin
          state_d = OCC_EMPTY;
        end
      endcase
    end
  end

  // Handshake outputs decoded from the occupancy register.
  always_comb begin
    out_data = main_q;
    case (state_q)
      OCC_EMPTY: begin
        out_valid = 1'b0;
        in_ready  = 1'b1;
      end
      OCC_ONE: begin
        out_valid = 1'b1;
        in_ready  = 1'b1;
      end
      OCC_FULL: begin
        out_valid = 1'b1;
        in_ready  = 1'b0;
      end
      default: begin
        out_valid = 1'b0;
        in_ready  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/operand_sel_pipe.sv
// Registered N:1 operand selector with valid/ready skid buffering and an
// illegal-select flag. Define OPERAND_SEL_ERRCNT_EN to build the saturating err_count.
module operand_sel_pipe
  import mips_pipe_pkg::*;
#(
  parameter  int WIDTH     = 32,
  parameter  int NUM_SRC   = 3,
  parameter  int ERR_CNT_W = 16,
  localparam int SEL_W     = $clog2(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [SEL_W-1:0]         sel,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_sel_err,
  output logic [ERR_CNT_W-1:0]     err_count
);

  logic [WIDTH-1:0] sel_data;
  logic             sel_err;

  // AND-OR select: codes with no matching source yield zero data and err set.
  always_comb begin
    sel_data = '0;
    sel_err  = 1'b1;
    for (int k = 0; k < NUM_SRC; k++) begin
      sel_data = sel_data | ({WIDTH{sel == SEL_W'(k)}} & src_data[k*WIDTH +: WIDTH]);
      sel_err  = sel_err & (sel != SEL_W'(k));
    end
  end

  operand_skid_buf #(
    .PAYLOAD_W (WIDTH + 1)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({sel_data, sel_err}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  ({out_data, out_sel_err})
  );

`ifdef OPERAND_SEL_ERRCNT_EN
  logic                 accept;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  assign accept = in_valid && in_ready && !flush;

  // Saturating count of accepted illegal-select beats; flush leaves it alone.
  always_comb begin
    if (accept && sel_err && (err_count_q != {ERR_CNT_W{1'b1}})) begin
      err_count_d = err_count_q + ERR_CNT_W'(1);
    end else begin
      err_count_d = err_count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_operand_sel_pipe.sv
// Self-checking bench: a default 32-bit/3-source instance and an 8-bit/5-source
// instance, each checked every cycle against a queue-based reference model.
module tb_operand_sel_pipe;
  import mips_pipe_pkg::*;

  localparam int WA = 32;
  localparam int NA = 3;
  localparam int EA = 16;
  localparam int SA = $clog2(NA);
  localparam int WB = 8;
  localparam int NB = 5;
  localparam int EB = 4;
  localparam int SB = $clog2(NB);
`ifdef OPERAND_SEL_ERRCNT_EN
  localparam bit ERRCNT_EN = 1'b1;
`else
  localparam bit ERRCNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_sel_err_a;
  logic [NA*WA-1:0] src_a;
  logic [SA-1:0]    sel_a;
  logic [WA-1:0]    out_data_a;
  logic [EA-1:0]    err_count_a;
  logic flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_sel_err_b;
  logic [NB*WB-1:0] src_b;
  logic [SB-1:0]    sel_b;
  logic [WB-1:0]    out_data_b;
  logic [EB-1:0]    err_count_b;

  operand_sel_pipe #(.WIDTH(WA), .NUM_SRC(NA), .ERR_CNT_W(EA)) dut_a (
    .clk(clk), .rst(rst), .flush(flush_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .src_data(src_a), .sel(sel_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_data(out_data_a), .out_sel_err(out_sel_err_a), .err_count(err_count_a)
  );

  operand_sel_pipe #(.WIDTH(WB), .NUM_SRC(NB), .ERR_CNT_W(EB)) dut_b (
    .clk(clk), .rst(rst), .flush(flush_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .src_data(src_b), .sel(sel_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_data(out_data_b), .out_sel_err(out_sel_err_b), .err_count(err_count_b)
  );

  int tests_run = 0;
  int failures  = 0;

  // Reference model state: queue of held beats {err, data}, last shown beat, error count.
  logic [WA:0] qa[$];
  logic [WA:0] last_a = '0;
  int          cnt_a  = 0;
  logic [WB:0] qb[$];
  logic [WB:0] last_b = '0;
  int          cnt_b  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WA:0] ref_a(input logic [NA*WA-1:0] src, input int s);
    logic [WA:0] r;
    r = '0;
    if (s < NA) r[WA-1:0] = src[s*WA +: WA];
    else        r[WA] = 1'b1;
    return r;
  endfunction

  function automatic logic [WB:0] ref_b(input logic [NB*WB-1:0] src, input int s);
    logic [WB:0] r;
    r = '0;
    if (s < NB) r[WB-1:0] = src[s*WB +: WB];
    else        r[WB] = 1'b1;
    return r;
  endfunction

  task automatic model_a();
    logic [WA:0] beat;
    if (rst) begin
      qa.delete(); last_a = '0; cnt_a = 0;
    end else if (flush_a) begin
      qa.delete(); last_a = '0;
    end else begin
      beat = ref_a(src_a, int'(sel_a));
      if (in_valid_a && qa.size() < 2) begin
        if (out_ready_a && qa.size() > 0) void'(qa.pop_front());
        qa.push_back(beat);
        if (beat[WA] && cnt_a < (1 << EA) - 1) cnt_a++;
      end else if (out_ready_a && qa.size() > 0) begin
        void'(qa.pop_front());
      end
      if (qa.size() > 0) last_a = qa[0];
    end
  endtask

  task automatic model_b();
    logic [WB:0] beat;
    if (rst) begin
      qb.delete(); last_b = '0; cnt_b = 0;
    end else if (flush_b) begin
      qb.delete(); last_b = '0;
    end else begin
      beat = ref_b(src_b, int'(sel_b));
      if (in_valid_b && qb.size() < 2) begin
        if (out_ready_b && qb.size() > 0) void'(qb.pop_front());
        qb.push_back(beat);
        if (beat[WB] && cnt_b < (1 << EB) - 1) cnt_b++;
      end else if (out_ready_b && qb.size() > 0) begin
        void'(qb.pop_front());
      end
      if (qb.size() > 0) last_b = qb[0];
    end
  endtask

  task automatic check_models();
    check("a_out_valid", 64'(out_valid_a), 64'(qa.size() > 0));
    check("a_in_ready", 64'(in_ready_a), 64'(qa.size() < 2));
    check("a_out_data", 64'(out_data_a), 64'(last_a[WA-1:0]));
    check("a_sel_err", 64'(out_sel_err_a), 64'(last_a[WA]));
    check("a_err_count", 64'(err_count_a), 64'(ERRCNT_EN ? cnt_a : 0));
    check("b_out_valid", 64'(out_valid_b), 64'(qb.size() > 0));
    check("b_in_ready", 64'(in_ready_b), 64'(qb.size() < 2));
    check("b_out_data", 64'(out_data_b), 64'(last_b[WB-1:0]));
    check("b_sel_err", 64'(out_sel_err_b), 64'(last_b[WB]));
    check("b_err_count", 64'(err_count_b), 64'(ERRCNT_EN ? cnt_b : 0));
  endtask

  task automatic tick();
    @(posedge clk);
    model_a();
    model_b();
    #1;
    check_models();
  endtask

  task automatic set_word_a(input int k, input logic [WA-1:0] v);
    src_a = '0;
    src_a[k*WA +: WA] = v;
  endtask

  initial begin
    int prior_cnt;
    logic [WB-1:0] wexp;
    rst = 1'b1;
    flush_a = 1'b0; in_valid_a = 1'b0; out_ready_a = 1'b0; src_a = '0; sel_a = '0;
    flush_b = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b0; src_b = '0; sel_b = '0;
    tick();
    tick();
    check("rst_out_valid", 64'(out_valid_a), 64'(0));
    check("rst_in_ready", 64'(in_ready_a), 64'(1));
    check("rst_out_data", 64'(out_data_a), 64'(0));
    check("rst_err_count", 64'(err_count_a), 64'(0));
    rst = 1'b0;

    // Basic select with out_ready held high.
    for (int k = 0; k < NA; k++) src_a[k*WA +: WA] = WA'(32'h11111111 * (k + 1));
    in_valid_a = 1'b1;
    out_ready_a = 1'b1;
    for (int s = 0; s < NA; s++) begin
      sel_a = SA'(s);
      tick();
      check("basic_data", 64'(out_data_a), 64'(32'h11111111 * (s + 1)));
      check("basic_err", 64'(out_sel_err_a), 64'(0));
    end

    sel_a = SA'(3);
    tick();
    check("illegal_data", 64'(out_data_a), 64'(0));
    check("illegal_err", 64'(out_sel_err_a), 64'(1));
    check("illegal_count", 64'(err_count_a), 64'(ERRCNT_EN ? 1 : 0));

    // Backpressure: A in main, B in skid, C refused until space frees.
    in_valid_a = 1'b0;
    tick();
    out_ready_a = 1'b0;
    in_valid_a = 1'b1;
    sel_a = SA'(SEL_EXMEM);
    set_word_a(1, 32'hA0A0_A0A0);
    tick();
    set_word_a(1, 32'hB1B1_B1B1);
    tick();
    check("bp_full_ready", 64'(in_ready_a), 64'(0));
    set_word_a(1, 32'hC2C2_C2C2);
    tick();
    check("bp_hold_ready", 64'(in_ready_a), 64'(0));
    check("bp_hold_data", 64'(out_data_a), 64'(32'hA0A0_A0A0));
    out_ready_a = 1'b1;
    tick();
    check("bp_order_b", 64'(out_data_a), 64'(32'hB1B1_B1B1));
    tick();
    check("bp_order_c", 64'(out_data_a), 64'(32'hC2C2_C2C2));
    in_valid_a = 1'b0;
    tick();
    check("bp_empty_valid", 64'(out_valid_a), 64'(0));
    check("bp_empty_hold", 64'(out_data_a), 64'(32'hC2C2_C2C2));

    // Flush while FULL with an illegal beat presented.
    out_ready_a = 1'b0;
    in_valid_a = 1'b1;
    sel_a = SA'(SEL_MEMWB);
    set_word_a(2, 32'hD3D3_D3D3);
    tick();
    tick();
    prior_cnt = ERRCNT_EN ? cnt_a : 0;
    flush_a = 1'b1;
    sel_a = SA'(3);
    tick();
    check("flush_valid", 64'(out_valid_a), 64'(0));
    check("flush_ready", 64'(in_ready_a), 64'(1));
    check("flush_count", 64'(err_count_a), 64'(prior_cnt));
    check("flush_data", 64'(out_data_a), 64'(0));
    flush_a = 1'b0;
    in_valid_a = 1'b0;
    out_ready_a = 1'b1;
    tick();
    check("flush_no_deliver", 64'(out_valid_a), 64'(0));

    // Sel sweep over the whole code space of the 5-source instance.
    for (int k = 0; k < NB; k++) src_b[k*WB +: WB] = WB'($urandom());
    in_valid_b = 1'b1;
    out_ready_b = 1'b1;
    for (int s = 0; s < 8; s++) begin
      sel_b = SB'(s);
      tick();
      wexp = (s < NB) ? src_b[s*WB +: WB] : WB'(0);
      check("sweep_data", 64'(out_data_b), 64'(wexp));
      check("sweep_err", 64'(out_sel_err_b), 64'(s >= NB));
    end

    for (int i = 0; i < 20; i++) begin
      sel_b = SB'($urandom_range(7, 5));
      tick();
    end
    in_valid_b = 1'b0;
    tick();
    check("sat_count", 64'(err_count_b), 64'(ERRCNT_EN ? 15 : 0));
    rst = 1'b1;
    tick();
    check("sat_rst_clear", 64'(err_count_b), 64'(0));
    rst = 1'b0;

    // Randomised traffic on both instances.
    for (int n = 0; n < 800; n++) begin
      for (int k = 0; k < NA; k++) src_a[k*WA +: WA] = WA'($urandom());
      for (int k = 0; k < NB; k++) src_b[k*WB +: WB] = WB'($urandom());
      sel_a       = SA'($urandom_range(3, 0));
      sel_b       = SB'($urandom_range(7, 0));
      in_valid_a  = ($urandom_range(3, 0) != 0);
      in_valid_b  = ($urandom_range(3, 0) != 0);
      out_ready_a = ($urandom_range(2, 0) != 0);
      out_ready_b = ($urandom_range(2, 0) != 0);
      flush_a     = ($urandom_range(19, 0) == 0);
      flush_b     = ($urandom_range(19, 0) == 0);
      rst         = ($urandom_range(99, 0) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/operand_sel_pipe.md
# operand_sel_pipe

Parametrised, registered N:1 operand selector with a valid/ready handshake and a 2-entry skid buffer. It is the pipelined successor to the unregistered 3-way 32-bit datapath mux. It sits between the forwarding logic and the ALU/branch-compare inputs of the MIPS core, so stalls and flushes propagate cleanly. Unlike the plain mux, every select code has defined behaviour (out-of-range selects zero) and an illegal-select diagnostic.

## Interface
- WIDTH, 32, data width of each source and of the output
- NUM_SRC, 3, number of sources, legal range 2..16; SEL_W = $clog2(NUM_SRC) is a derived localparam
- ERR_CNT_W, 16, width of the illegal-select counter
- clk  in  1  clock; all logic is rising-edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous pipeline flush; drops all held beats
- in_valid  in  1  upstream beat valid
- in_ready  out  1  block can accept a beat this cycle
- src_data  in  NUM_SRC*WIDTH  packed sources; source k is src_data[k*WIDTH +: WIDTH]
- sel  in  SEL_W  source index, sampled with the beat
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data this cycle
- out_data  out  WIDTH  selected operand
- out_sel_err  out  1  current output beat was produced from an illegal sel
- err_count  out  ERR_CNT_W  saturating count of illegal-select beats (see Configuration)

## Operation
- A beat is accepted when in_valid && in_ready && !flush. A beat is delivered when out_valid && out_ready.
- Selection:
  - sel < NUM_SRC: data = source sel, err = 0.
  - sel >= NUM_SRC: data = 0, err = 1.
  - No latches, no held value.
- Storage is a main register (drives the outputs) and one skid register. Occupancy state:
  - EMPTY: out_valid = 0.
  - ONE: main valid, skid empty.
  - FULL: main and skid valid.
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept without deliver -> FULL; the new beat goes to skid.
  - ONE + accept and deliver -> ONE; main takes the new beat.
  - ONE + deliver only -> EMPTY.
  - FULL + deliver -> ONE; skid moves to main. No accept is possible in FULL.
- in_ready = !skid_valid, driven from a register with no combinational path from out_ready.
- Beats leave in acceptance order. No beat is dropped or duplicated except by flush or rst.
- flush has priority over accept and deliver. Next cycle the state is EMPTY, both valids are 0, and in_ready = 1. A beat presented during flush is not accepted.
- The flush/rst clearing that sets out_data/out_sel_err to 0 is a reset value. It is not a side effect of emptying: on a normal deliver to EMPTY, out_data and out_sel_err hold their last value while out_valid = 0.

## Timing
- Latency is 1 cycle: a beat accepted at edge n is on out_data with out_valid = 1 after edge n, provided main was free or is delivered at edge n.
- Sustained throughput is 1 beat/cycle when out_ready = 1.
- rst (synchronous), reset values: out_valid = 0, out_data = 0, out_sel_err = 0, in_ready = 1, err_count = 0, skid cleared.
- rst asserted mid-transfer discards main and skid contents at that edge.
- flush behaves like rst but does not clear err_count.
- out_data and out_sel_err are stable while out_valid && !out_ready.

## Configuration
- OPERAND_SEL_ERRCNT_EN defined:
  - err_count increments by 1 on each accepted beat with illegal sel.
  - It saturates at 2^ERR_CNT_W - 1 and is cleared only by rst.
- OPERAND_SEL_ERRCNT_EN undefined:
  - Counter logic is removed and err_count is tied to 0.
  - out_sel_err still functions.

## Structure
- Shared package mips_pipe_pkg holds the operand-select encodings for the 3-source MIPS configuration:
  - SEL_REG = 0
  - SEL_EXMEM = 1
  - SEL_MEMWB = 2
- The same package holds a typedef for the {data, err} beat.
- One sub-module, operand_skid_buf: a generic 2-entry valid/ready skid register parametrised on payload width. operand_sel_pipe instantiates it with payload WIDTH+1.
- Selection and counter logic live in the top.

## Test plan
- Basic select, defaults, out_ready = 1: sources 0x11111111 / 0x22222222 / 0x33333333 with sel 0, 1, 2 in successive cycles -> the same values appear one cycle later, out_sel_err = 0.
- Illegal select: sel = 3 with NUM_SRC = 3 -> out_data = 0 and out_sel_err = 1. With the macro, err_count goes 0 -> 1; without it, err_count stays 0.
- Backpressure:
  - Hold out_ready = 0 and present 3 beats: A is in main, B in skid, and in_ready drops to 0 after the second accept, so C is not accepted.
  - Release out_ready: A, B, C are delivered in order with no loss.
- Flush while FULL: flush = 1 with in_valid = 1 -> next cycle out_valid = 0, in_ready = 1, the presented beat is not delivered, and err_count is unchanged.
- Saturation, ERR_CNT_W = 4 with the macro: 20 accepted illegal beats -> err_count = 15. A synchronous rst clears it to 0 at the next edge.
- Parametrisation: WIDTH = 8, NUM_SRC = 5, a full sel sweep 0..7 -> sel 0..4 return their sources and sel 5..7 return 0 with out_sel_err = 1.
